// File: rtl/riscv_ctrl.sv
// ============================================================================
// Module      : riscv_ctrl
// Description : Single-cycle RV32I control unit with a sticky illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  output logic       pcSrc,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic [1:0] Immsrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic       illegal_sticky
);

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
  localparam logic [6:0] c_OP_IALU = 7'b0010011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;

  logic       w_reg_write_main;
  logic [1:0] w_imm_src;
  logic       w_alu_src;
  logic       w_mem_write;
  logic [1:0] w_result_src;
  logic       w_branch;
  logic       w_jump;
  logic [1:0] w_alu_op;
  logic       w_illegal_op;
  logic [2:0] w_alu_control;
  logic       w_illegal_f3;
  logic       illegal_sticky_q;
  logic       illegal_sticky_d;

  always_comb begin
    w_reg_write_main = 1'b0;
    w_imm_src        = 2'b00;
    w_alu_src        = 1'b0;
    w_mem_write      = 1'b0;
    w_result_src     = 2'b00;
    w_branch         = 1'b0;
    w_jump           = 1'b0;
    w_alu_op         = 2'b00;
    w_illegal_op     = 1'b0;
    case (op)
      c_OP_LW: begin
        w_reg_write_main = 1'b1;
        w_alu_src        = 1'b1;
        w_result_src     = 2'b01;
      end
      c_OP_SW: begin
        w_imm_src   = 2'b01;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_OP_R: begin
        w_reg_write_main = 1'b1;
        w_alu_op         = 2'b10;
      end
      c_OP_BEQ: begin
        w_imm_src = 2'b10;
        w_branch  = 1'b1;
        w_alu_op  = 2'b01;
      end
      c_OP_IALU: begin
        w_reg_write_main = 1'b1;
        w_alu_src        = 1'b1;
        w_alu_op         = 2'b10;
      end
      c_OP_JAL: begin
        w_reg_write_main = 1'b1;
        w_imm_src        = 2'b11;
        w_result_src     = 2'b10;
        w_jump           = 1'b1;
      end
      default: w_illegal_op = 1'b1;
    endcase
  end

  // Only R-type (op[5] set) with funct7 bit 5 subtracts; addi always adds.
  always_comb begin
    w_alu_control = 3'b000;
    w_illegal_f3  = 1'b0;
    case (w_alu_op)
      2'b01: w_alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  w_alu_control = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_illegal_f3  = 1'b1;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  assign pcSrc          = (w_branch & zero) | w_jump;
  assign ResultSrc      = w_result_src;
  assign MemWrite       = w_mem_write;
  assign ALUSrc         = w_alu_src;
  assign Immsrc         = w_imm_src;
  assign RegWrite       = w_reg_write_main & ~w_illegal_f3;
  assign ALUControl     = w_alu_control;
  assign illegal        = w_illegal_op | w_illegal_f3;
  assign illegal_sticky = illegal_sticky_q;

  assign illegal_sticky_d = illegal_sticky_q | illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_sticky_q <= 1'b0;
    end else begin
      illegal_sticky_q <= illegal_sticky_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_ctrl.sv
// ============================================================================
// Module      : tb_riscv_ctrl
// Description : Directed and random checks of riscv_ctrl against a class model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       pcSrc;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       ALUSrc;
  logic [1:0] Immsrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       illegal;
  logic       illegal_sticky;

  int checks = 0;
  int errors = 0;
  bit exp_sticky;

  riscv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .pcSrc(pcSrc), .ResultSrc(ResultSrc), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .Immsrc(Immsrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .illegal(illegal), .illegal_sticky(illegal_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] c_ADD = 3'b000;
  localparam logic [2:0] c_SUB = 3'b001;
  localparam logic [2:0] c_AND = 3'b010;
  localparam logic [2:0] c_OR  = 3'b011;
  localparam logic [2:0] c_SLT = 3'b101;

  // Expected bundle {pcSrc, ResultSrc, MemWrite, ALUSrc, Immsrc, RegWrite, ALUControl, illegal}
  function automatic logic [11:0] model(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic z);
    bit       rw = 0, asrc = 0, mw = 0, pcs = 0, ill = 0;
    bit [1:0] rs = 0, imm = 0;
    bit [2:0] alu = c_ADD;
    case (o)
      7'b0000011: begin rw = 1; asrc = 1; rs = 2'd1; end
      7'b0100011: begin imm = 2'd1; asrc = 1; mw = 1; end
      7'b1100011: begin imm = 2'd2; alu = c_SUB; pcs = z; end
      7'b1101111: begin rw = 1; imm = 2'd3; rs = 2'd2; pcs = 1; end
      7'b0110011, 7'b0010011: begin
        rw   = 1;
        asrc = (o == 7'b0010011);
        if (f3 == 3'd0)      alu = (o == 7'b0110011 && f7) ? c_SUB : c_ADD;
        else if (f3 == 3'd2) alu = c_SLT;
        else if (f3 == 3'd6) alu = c_OR;
        else if (f3 == 3'd7) alu = c_AND;
        else begin rw = 0; ill = 1; end
      end
      default: ill = 1;
    endcase
    return {pcs, rs, mw, asrc, imm, rw, alu, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dut_bundle();
    return {pcSrc, ResultSrc, MemWrite, ALUSrc, Immsrc, RegWrite, ALUControl, illegal};
  endfunction

  // Drive one instruction, check decode, clock it, then check the sticky flag.
  task automatic step(input string tag, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z);
    logic [11:0] exp;
    op = o; funct3 = f3; funct7 = f7; zero = z;
    #2;
    exp = model(o, f3, f7, z);
    check({tag, "_decode"}, {20'd0, dut_bundle()}, {20'd0, exp});
    @(posedge clk);
    exp_sticky = exp_sticky | exp[0];
    #1;
    check({tag, "_sticky"}, {31'd0, illegal_sticky}, {31'd0, exp_sticky});
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    exp_sticky = 1'b0;
    check({tag, "_rst_sticky"}, {31'd0, illegal_sticky}, 32'd0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [6:0] legal_ops [6];
    logic [6:0] o;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111};
    exp_sticky = 1'b0;

    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0;
    #2;
    check("reset_sticky", {31'd0, illegal_sticky}, 32'd0);
    check("reset_lw_decode", {20'd0, dut_bundle()}, {20'd0, model(7'b0000011, 3'd0, 1'b0, 1'b0)});
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("lw",        7'b0000011, 3'd2, 1'b0, 1'b0);
    check("lw_fixed", {20'd0, dut_bundle()}, {20'd0, 12'b0_01_0_1_00_1_000_0});
    step("sw",        7'b0100011, 3'd2, 1'b0, 1'b0);
    step("jal_z0",    7'b1101111, 3'd0, 1'b0, 1'b0);
    step("jal_z1",    7'b1101111, 3'd5, 1'b1, 1'b1);
    step("beq_z1",    7'b1100011, 3'd3, 1'b0, 1'b1);
    check("beq_fixed", {20'd0, dut_bundle()}, {20'd0, 12'b1_00_0_0_10_0_001_0});
    step("beq_z0",    7'b1100011, 3'd0, 1'b0, 1'b0);
    step("addi_f7",   7'b0010011, 3'd0, 1'b1, 1'b0);
    step("sub",       7'b0110011, 3'd0, 1'b1, 1'b0);
    check("sub_fixed", {29'd0, ALUControl}, {29'd0, c_SUB});
    step("slt",       7'b0110011, 3'd2, 1'b0, 1'b0);
    step("or",        7'b0110011, 3'd6, 1'b0, 1'b0);
    step("and",       7'b0110011, 3'd7, 1'b0, 1'b1);
    check("and_fixed", {29'd0, ALUControl}, {29'd0, c_AND});
    step("illegal_op", 7'b1111111, 3'd0, 1'b0, 1'b1);
    check("illegal_fixed", {20'd0, dut_bundle()}, 32'd1);
    step("lw_after_ill", 7'b0000011, 3'd0, 1'b0, 1'b0);
    check("sticky_held", {31'd0, illegal_sticky}, 32'd1);
    reset_pulse("mid");
    step("r_f3_001",  7'b0110011, 3'd1, 1'b0, 1'b0);
    reset_pulse("mid2");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) < 6) o = legal_ops[$urandom_range(0, 5)];
      else                          o = 7'($urandom);
      step("rand", o, 3'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 39) == 0) reset_pulse("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
